// File: rtl/memory_io_unit.sv
// memory_io_unit: CPU-facing RAM plus LED, timer, TX FIFO and status registers
// behind a single registered read port.
module memory_io_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int RAM_ADDR_SIZE = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] memory_addr,
  input  logic [WORD_SIZE-1:0] memory_out,
  input  logic                 memory_write,
  output logic [WORD_SIZE-1:0] memory_in,
  output logic [WORD_SIZE-1:0] leds,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [WORD_SIZE-1:0] A_LED = WORD_SIZE'(16'hFF00);
  localparam logic [WORD_SIZE-1:0] A_TMR = WORD_SIZE'(16'hFF01);
  localparam logic [WORD_SIZE-1:0] A_TX  = WORD_SIZE'(16'hFF02);
  localparam logic [WORD_SIZE-1:0] A_ST  = WORD_SIZE'(16'hFF03);
  logic [WORD_SIZE-1:0] r_ram [2**RAM_ADDR_SIZE];
  logic [WORD_SIZE-1:0] r_fifo [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] r_memory_in, r_leds, r_timer;
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf, r_drop;
  logic                 w_sel_ram, w_sel_led, w_sel_tmr, w_sel_tx, w_sel_st;
  logic                 w_full, w_empty, w_pop, w_push_req, w_push, w_drop, w_wrap;
  logic                 w_tmr_wr, w_st_wr;
  logic [WORD_SIZE-1:0] w_status, w_rdata;
  assign w_sel_ram  = memory_addr[WORD_SIZE-1:RAM_ADDR_SIZE] == '0;
  assign w_sel_led  = memory_addr == A_LED;
  assign w_sel_tmr  = memory_addr == A_TMR;
  assign w_sel_tx   = memory_addr == A_TX;
  assign w_sel_st   = memory_addr == A_ST;
  assign w_tmr_wr   = memory_write && w_sel_tmr;
  assign w_st_wr    = memory_write && w_sel_st;
  assign w_full     = r_count == CW'(FIFO_DEPTH);
  assign w_empty    = r_count == '0;
  assign w_pop      = !w_empty && tx_ready;
  assign w_push_req = memory_write && w_sel_tx;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;
  assign w_wrap     = r_timer == '1 && !w_tmr_wr;
  assign w_status   = {(WORD_SIZE-4)'(0), r_drop, r_ovf, w_empty, w_full};
  assign w_rdata    = w_sel_ram ? r_ram[memory_addr[RAM_ADDR_SIZE-1:0]] :
                      w_sel_led ? r_leds :
                      w_sel_tmr ? r_timer :
                      w_sel_st  ? w_status : '0;
  assign memory_in  = r_memory_in;
  assign leds       = r_leds;
  assign tx_valid   = !w_empty;
  assign tx_data    = w_empty ? '0 : r_fifo[r_rptr];
  always_ff @(posedge clk)
    if (reset && memory_write && w_sel_ram) r_ram[memory_addr[RAM_ADDR_SIZE-1:0]] <= memory_out;
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wptr] <= memory_out;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_memory_in <= '0;
      r_leds      <= '0;
      r_timer     <= '0;
      r_ovf       <= 1'b0;
      r_drop      <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_memory_in <= w_rdata;
      if (memory_write && w_sel_led) r_leds <= memory_out;
      r_timer     <= w_tmr_wr ? memory_out : r_timer + 1'b1;
      // set beats clear when both land in the same cycle
      r_ovf       <= w_wrap || (r_ovf && !(w_st_wr && memory_out[2]));
      r_drop      <= w_drop || (r_drop && !(w_st_wr && memory_out[3]));
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: tb/tb_memory_io_unit.sv
// tb_memory_io_unit: directed vector table, hand sequences for reset and flag
// races, then random traffic against a queue-based reference model.
module tb_memory_io_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memory_addr, memory_out, memory_in, leds, tx_data;
  logic        memory_write, tx_valid, tx_ready;
  int          n_chk = 0;
  int          n_fail = 0;
  memory_io_unit dut (
    .clk(clk), .reset(reset), .memory_addr(memory_addr), .memory_out(memory_out),
    .memory_write(memory_write), .memory_in(memory_in), .leds(leds),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a, d;
    bit          we, rdy, crd;
    logic [15:0] rd, l;
    bit          v;
    logic [15:0] t;
  } vec_t;
  vec_t tv [29];
  function automatic vec_t mk(input logic [15:0] a, d, input bit we, rdy, crd,
                              input logic [15:0] rd, l, input bit v, input logic [15:0] t);
    mk = '{a, d, we, rdy, crd, rd, l, v, t};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [15:0] a, d, input bit we, rdy);
    memory_addr = a; memory_out = d; memory_write = we; tx_ready = rdy;
    @(posedge clk); #1;
  endtask
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_leds, m_timer;
  bit          m_ovf, m_drop;
  logic [15:0] m_q [$];
  task automatic model_reset();
    m_leds = 0; m_timer = 0; m_ovf = 0; m_drop = 0; m_q.delete();
    foreach (m_known[i]) m_known[i] = 0;
  endtask
  task automatic mcyc(input logic [15:0] a, d, input bit we, rdy);
    logic [15:0] e_rd;
    bit full, pop, crd, set_ovf, set_drop;
    full = m_q.size() == 4;
    crd = a >= 256 || m_known[a[7:0]];
    e_rd = a < 256 ? m_ram[a[7:0]] : a == 16'hFF00 ? m_leds : a == 16'hFF01 ? m_timer :
           a == 16'hFF03 ? {12'b0, m_drop, m_ovf, m_q.size() == 0, full} : 16'h0;
    pop = rdy && m_q.size() > 0;
    set_ovf = 0; set_drop = 0;
    if (we && a < 256) begin m_ram[a[7:0]] = d; m_known[a[7:0]] = 1; end
    if (we && a == 16'hFF00) m_leds = d;
    if (we && a == 16'hFF01) m_timer = d;
    else begin set_ovf = m_timer == 16'hFFFF; m_timer = m_timer + 1; end
    if (we && a == 16'hFF03) begin if (d[2]) m_ovf = 0; if (d[3]) m_drop = 0; end
    if (pop) void'(m_q.pop_front());
    if (we && a == 16'hFF02) begin
      if (full && !pop) set_drop = 1; else m_q.push_back(d);
    end
    m_ovf = m_ovf | set_ovf; m_drop = m_drop | set_drop;
    drive(a, d, we, rdy);
    if (crd) chk("model rd", memory_in, e_rd);
    chk("model leds", leds, m_leds);
    chk("model valid", {15'b0, tx_valid}, {15'b0, m_q.size() > 0});
    chk("model txd", tx_data, m_q.size() > 0 ? m_q[0] : 16'h0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int r;
    logic [15:0] a, d;
    tv[0]  = mk(16'h0005, 16'h1234, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    tv[1]  = mk(16'h0005, 16'h0000, 0, 0, 1, 16'h1234, 16'h0000, 0, 16'h0000);
    tv[2]  = mk(16'hFF00, 16'hA5A5, 1, 0, 1, 16'h0000, 16'hA5A5, 0, 16'h0000);
    tv[3]  = mk(16'hFF00, 16'h0000, 0, 0, 1, 16'hA5A5, 16'hA5A5, 0, 16'h0000);
    tv[4]  = mk(16'h0000, 16'hBEEF, 1, 0, 0, 16'h0000, 16'hA5A5, 0, 16'h0000);
    tv[5]  = mk(16'h1000, 16'hDEAD, 1, 0, 1, 16'h0000, 16'hA5A5, 0, 16'h0000);
    tv[6]  = mk(16'h1000, 16'h0000, 0, 0, 1, 16'h0000, 16'hA5A5, 0, 16'h0000);
    tv[7]  = mk(16'h0000, 16'h0000, 0, 0, 1, 16'hBEEF, 16'hA5A5, 0, 16'h0000);
    tv[8]  = mk(16'hFF01, 16'hFFFE, 1, 0, 1, 16'h0008, 16'hA5A5, 0, 16'h0000);
    tv[9]  = mk(16'hFF01, 16'h0000, 0, 0, 1, 16'hFFFE, 16'hA5A5, 0, 16'h0000);
    tv[10] = mk(16'hFF01, 16'h0000, 0, 0, 1, 16'hFFFF, 16'hA5A5, 0, 16'h0000);
    tv[11] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h0006, 16'hA5A5, 0, 16'h0000);
    tv[12] = mk(16'hFF03, 16'h0004, 1, 0, 1, 16'h0006, 16'hA5A5, 0, 16'h0000);
    tv[13] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h0002, 16'hA5A5, 0, 16'h0000);
    tv[14] = mk(16'hFF02, 16'h1111, 1, 0, 1, 16'h0000, 16'hA5A5, 1, 16'h1111);
    tv[15] = mk(16'hFF02, 16'h2222, 1, 0, 1, 16'h0000, 16'hA5A5, 1, 16'h1111);
    tv[16] = mk(16'hFF02, 16'h3333, 1, 0, 1, 16'h0000, 16'hA5A5, 1, 16'h1111);
    tv[17] = mk(16'hFF02, 16'h4444, 1, 0, 1, 16'h0000, 16'hA5A5, 1, 16'h1111);
    tv[18] = mk(16'hFF02, 16'h5555, 1, 0, 1, 16'h0000, 16'hA5A5, 1, 16'h1111);
    tv[19] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h0009, 16'hA5A5, 1, 16'h1111);
    tv[20] = mk(16'hFF02, 16'h6666, 1, 1, 1, 16'h0000, 16'hA5A5, 1, 16'h2222);
    tv[21] = mk(16'hFF03, 16'h0000, 0, 1, 1, 16'h0009, 16'hA5A5, 1, 16'h3333);
    tv[22] = mk(16'hFF03, 16'h0000, 0, 1, 1, 16'h0008, 16'hA5A5, 1, 16'h4444);
    tv[23] = mk(16'hFF03, 16'h0000, 0, 1, 1, 16'h0008, 16'hA5A5, 1, 16'h6666);
    tv[24] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h0008, 16'hA5A5, 1, 16'h6666);
    tv[25] = mk(16'hFF03, 16'h0000, 0, 1, 1, 16'h0008, 16'hA5A5, 0, 16'h0000);
    tv[26] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h000A, 16'hA5A5, 0, 16'h0000);
    tv[27] = mk(16'hFF03, 16'h0008, 1, 0, 1, 16'h000A, 16'hA5A5, 0, 16'h0000);
    tv[28] = mk(16'hFF03, 16'h0000, 0, 0, 1, 16'h0002, 16'hA5A5, 0, 16'h0000);
    reset = 1'b0; memory_addr = 0; memory_out = 0; memory_write = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset memory_in", memory_in, 16'h0);
    chk("reset leds", leds, 16'h0);
    chk("reset tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("reset tx_data", tx_data, 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(tv[i].a, tv[i].d, tv[i].we, tv[i].rdy);
      if (tv[i].crd) chk($sformatf("vec%0d memory_in", i), memory_in, tv[i].rd);
      chk($sformatf("vec%0d leds", i), leds, tv[i].l);
      chk($sformatf("vec%0d tx_valid", i), {15'b0, tx_valid}, {15'b0, tv[i].v});
      chk($sformatf("vec%0d tx_data", i), tx_data, tv[i].t);
    end
    drive(16'hFF01, 16'h1234, 1, 0);
    drive(16'hFF01, 16'h0000, 0, 0);
    chk("timer write no increment", memory_in, 16'h1234);
    drive(16'hFF01, 16'h0000, 0, 0);
    chk("timer increments after write", memory_in, 16'h1235);
    drive(16'hFF01, 16'hFFFF, 1, 0);
    drive(16'hFF03, 16'h0004, 1, 0);
    chk("status before race", memory_in, 16'h0002);
    drive(16'hFF03, 16'h0000, 0, 0);
    chk("ovf set beats clear", memory_in, 16'h0006);
    drive(16'hFF03, 16'h0004, 1, 0);
    drive(16'hFF03, 16'h0000, 0, 0);
    chk("ovf cleared", memory_in, 16'h0002);
    drive(16'hFF02, 16'h7001, 1, 0);
    drive(16'hFF02, 16'h7002, 1, 0);
    drive(16'hFF02, 16'h7003, 1, 0);
    drive(16'hFF00, 16'h00C3, 1, 0);
    drive(16'hFF00, 16'h0000, 0, 0);
    chk("pre-reset memory_in", memory_in, 16'h00C3);
    chk("pre-reset tx_data", tx_data, 16'h7001);
    memory_write = 0;
    #2 reset = 1'b0;
    #1;
    chk("async reset tx_valid", {15'b0, tx_valid}, 16'h0);
    chk("async reset tx_data", tx_data, 16'h0);
    chk("async reset leds", leds, 16'h0);
    chk("async reset memory_in", memory_in, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    mcyc(16'hFF03, 16'h0, 0, 0);
    for (int i = 0; i < 256; i++) mcyc(16'(i), 16'($urandom), 1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = r < 4 ? 16'($urandom_range(0, 255)) : r < 8 ? 16'hFF00 + 16'(r - 4) :
          16'($urandom_range(256, 16'hFEFF));
      d = 16'($urandom);
      if (a == 16'hFF01) d = 16'hFFF0 | {12'h0, d[3:0]};
      mcyc(a, d, 1'($urandom_range(0, 1)),
           ((i / 200) % 2) != 0 ? $urandom_range(0, 9) < 7 : $urandom_range(0, 19) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_io_unit.md
MEMORY_IO_UNIT -- requirements
Module: memory_io_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning data and address width.
REQ-002 SHALL have parameter RAM_ADDR_SIZE, default 8, meaning log2 of RAM depth in words.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning TX FIFO entries.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port memory_addr  input  WORD_SIZE  CPU address.
REQ-007 SHALL have port memory_out  input  WORD_SIZE  CPU write data.
REQ-008 SHALL have port memory_write  input  1  CPU write strobe, one write per cycle high.
REQ-009 SHALL have port memory_in  output  WORD_SIZE  read data returned to the CPU.
REQ-010 SHALL have port leds  output  WORD_SIZE  LED output register.
REQ-011 SHALL have port tx_data  output  WORD_SIZE  FIFO head word.
REQ-012 SHALL have port tx_valid  output  1  FIFO not empty.
REQ-013 SHALL have port tx_ready  input  1  consumer accepts head word.

Function
REQ-014 SHALL decode the map: addr[15:RAM_ADDR_SIZE]==0 RAM; 0xFF00 LED; 0xFF01 TIMER; 0xFF02 TXDATA; 0xFF03 STATUS; all others unmapped.
REQ-015 SHALL register reads: memory_in at edge N+1 equals the content at memory_addr sampled at edge N, i.e. one-cycle read latency.
REQ-016 SHALL perform writes at the rising edge where memory_write=1; a read of the same address in the same cycle returns the old value.
REQ-017 SHALL return 0 for unmapped reads and for TXDATA reads, and ignore unmapped writes.
REQ-018 SHALL make LED read/write, with leds driven directly from the register.
REQ-019 SHALL increment TIMER by 1 every cycle and wrap 0xFFFF->0x0000, setting sticky STATUS[2] (timer overflow) on wrap.
REQ-020 SHALL give a TIMER write priority over the increment; the written value appears with no increment that cycle.
REQ-021 SHALL push memory_out into the FIFO on a TXDATA write when not full, or when full with a pop occurring the same cycle.
REQ-022 SHALL drop a TXDATA write otherwise (full, no pop) and set sticky STATUS[3] (drop).
REQ-023 SHALL pop on a cycle with tx_valid and tx_ready both high.
REQ-024 SHALL drive tx_data from the head entry, stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL provide no bypass: a push to an empty FIFO raises tx_valid at the following edge.
REQ-026 SHALL support a simultaneous push and pop at any occupancy, leaving the count unchanged (except the empty case, where only the push happens).
REQ-027 SHALL use wrapping read/write pointers plus an occupancy count 0..FIFO_DEPTH.
REQ-028 SHALL read STATUS as: bit0 full, bit1 empty, bit2 timer overflow, bit3 drop, other bits 0.
REQ-029 SHALL clear bit2/bit3 on a STATUS write with the corresponding bit=1; if a set event occurs in the same cycle as its clear, set wins.

Reset
REQ-030 SHALL, while reset=0, asynchronously force memory_in=0, leds=0, TIMER=0, FIFO empty (tx_valid=0, tx_data=0), and STATUS bits 2 and 3 to 0.
REQ-031 SHALL NOT initialise RAM contents on reset.
REQ-032 SHALL discard FIFO contents and any in-flight write on reset mid-operation; operation resumes on the first edge after reset=1.

Verification
REQ-033 SHALL pass: write 0x1234 to 0x0005, then read 0x0005 -> memory_in=0x1234 one cycle after the address is presented.
REQ-034 SHALL pass: write 0xFFFE to TIMER -> two edges later read value wraps; STATUS reads 0x0006 (empty, overflow); write STATUS 0x0004 -> bit2 cleared.
REQ-035 SHALL pass: with tx_ready=0, push 5 words A..E -> tx_valid=1, tx_data=A, STATUS bit0=1, bit3=1 after E is dropped.
REQ-036 SHALL pass: with FIFO full, push F while tx_ready=1 -> A popped, F accepted, count stays 4; subsequent order B,C,D,F.
REQ-037 SHALL pass: assert reset=0 mid-stream with 3 entries queued -> tx_valid=0, leds=0, memory_in=0 immediately, without waiting for a clock edge.
REQ-038 SHALL pass: write to 0x1000 (unmapped) then read it -> memory_in=0, and RAM word 0x0000 unchanged.
